// File: rtl/sample_pkg.sv
// Shared types and helpers for the sample collector and its neighbours.
package sample_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   function automatic int len_bits(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sample_collector_if.sv
// Sample stream in, lane vector out; the collector takes the slave side.
interface sample_collector_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   import sample_pkg::*;

   localparam int LW = len_bits(N);

   // Both streams: a transfer happens on a rising edge where valid && ready;
   // the source holds data stable and valid high until that transfer.
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] out_vec [N];
   logic [LW-1:0]    out_len;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_vec, out_len, out_valid
   );

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_vec, out_len, out_valid
   );

endinterface

// File: rtl/sample_collector.sv
// Packs N accepted samples (or fewer on flush, zero-padded) into a registered
// lane vector held until the downstream adder tree takes it.
module sample_collector
   import sample_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic   clk,
   input  logic   rst,
   sample_collector_if.slave bus,
   output state_t state_dbg
);

   localparam int LW = len_bits(N);

   state_t           state, state_n;
   logic [LW-1:0]    count, count_n;
   logic [LW-1:0]    len, len_n;
   logic [WIDTH-1:0] lanes   [N];
   logic [WIDTH-1:0] lanes_n [N];
   logic             accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         count <= '0;
         len   <= '0;
         for (int i = 0; i < N; i++) lanes[i] <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         len   <= len_n;
         lanes <= lanes_n;
      end
   end

   assign bus.in_ready  = (state == FILL) && !rst;
   assign bus.out_valid = (state == FULL);
   assign bus.out_len   = len;
   assign bus.out_vec   = lanes;
   assign state_dbg     = state;
   assign accept        = bus.in_valid && bus.in_ready;

   always_comb begin
      state_n = state;
      count_n = count;
      len_n   = len;
      lanes_n = lanes;
      case (state)
         FILL: begin
            if (accept) begin
               for (int i = 0; i < N; i++) begin
                  if (count == LW'(i)) lanes_n[i] = bus.in_data;
               end
               // A flush alongside an accept closes the vector including this sample.
               if (bus.flush || count == LW'(N - 1)) begin
                  state_n = FULL;
                  len_n   = count + LW'(1);
                  count_n = '0;
               end else begin
                  count_n = count + LW'(1);
               end
            end else if (bus.flush && count != '0) begin
               state_n = FULL;
               len_n   = count;
               count_n = '0;
            end
         end
         FULL: begin
            if (bus.out_ready) begin
               state_n = FILL;
               len_n   = '0;
               count_n = '0;
               for (int i = 0; i < N; i++) lanes_n[i] = '0;
            end
         end
         default: state_n = FILL;
      endcase
   end

endmodule

// File: tb/tb_sample_collector.sv
// Bench for sample_collector: directed scenarios plus random traffic against a
// queue-based model of what vectors should come out.
module tb_sample_collector;
   import sample_pkg::*;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int LW  = len_bits(N);
   localparam int WD  = N * W + LW;
   localparam int W3  = 4;
   localparam int N3  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sample_collector_if #(.WIDTH(W),  .N(N))  bus ();
   sample_collector_if #(.WIDTH(W3), .N(N3)) bus3 ();
   state_t st, st3;

   sample_collector #(.WIDTH(W), .N(N)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(st)
   );
   sample_collector #(.WIDTH(W3), .N(N3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3.slave), .state_dbg(st3)
   );

   int tests = 0;
   int fails = 0;
   int handshakes = 0;
   logic [W-1:0]  cur_q[$];
   logic [WD-1:0] exp_q[$];

   task automatic check(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WD-1:0] dut_word();
      logic [WD-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) w[i*W +: W] = bus.out_vec[i];
      w[N*W +: LW] = bus.out_len;
      return w;
   endfunction

   function automatic logic [WD-1:0] mk(input logic [W-1:0] a, b, c, d, input int len);
      logic [WD-1:0] w;
      w = '0;
      w[0*W +: W] = a;
      w[1*W +: W] = b;
      w[2*W +: W] = c;
      w[3*W +: W] = d;
      w[N*W +: LW] = LW'(len);
      return w;
   endfunction

   function automatic logic [W-1:0] lane_sum();
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s = s + bus.out_vec[i];
      return s;
   endfunction

   // Drive one cycle, check outputs against the model, then advance the model.
   task automatic step(input logic v, input logic [W-1:0] d, input logic f,
                       input logic ordy, input logic r);
      logic [WD-1:0] w;
      rst = r;
      bus.in_valid = v;
      bus.in_data = d;
      bus.flush = f;
      bus.out_ready = ordy;
      #1;
      check("in_ready", WD'(bus.in_ready), WD'(!r && exp_q.size() == 0));
      check("out_valid", WD'(bus.out_valid), WD'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("held_vec", dut_word(), exp_q[0]);
      if (r) begin
         cur_q.delete();
         exp_q.delete();
      end else if (exp_q.size() != 0) begin
         if (ordy) begin
            void'(exp_q.pop_front());
            handshakes++;
         end
      end else begin
         if (v) cur_q.push_back(d);
         if (cur_q.size() == N || (f && cur_q.size() != 0)) begin
            w = '0;
            foreach (cur_q[i]) w[i*W +: W] = cur_q[i];
            w[N*W +: LW] = LW'(cur_q.size());
            exp_q.push_back(w);
            cur_q.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_held(input string tag, input logic [WD-1:0] want);
      check({tag, "_valid"}, WD'(bus.out_valid), WD'(1));
      check(tag, dut_word(), want);
   endtask

   initial begin
      logic [W3-1:0] s3;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.flush = 1'b0; bus3.out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("rst_vec_len", dut_word(), '0);
      check("rst_state", WD'(st), WD'(FILL));

      // Basic fill
      step(1, 1, 0, 1, 0);
      step(1, 2, 0, 1, 0);
      step(1, 3, 0, 1, 0);
      step(1, 4, 0, 1, 0);
      check_held("basic", mk(1, 2, 3, 4, 4));
      check("basic_state", WD'(st), WD'(FULL));
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // Backpressure, with ignored samples and flushes during the hold
      step(1, 10, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      step(1, 30, 0, 0, 0);
      step(1, 40, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(i[0], 8'd99, i[1], 0, 0);
         check_held("bp_hold", mk(10, 20, 30, 40, 4));
      end
      step(0, 0, 0, 1, 0);
      step(1, 5, 0, 1, 0);
      step(1, 6, 0, 1, 0);
      step(1, 7, 0, 1, 0);
      step(1, 8, 0, 1, 0);
      check_held("bp_next", mk(5, 6, 7, 8, 4));
      step(0, 0, 0, 1, 0);

      // Flush partial
      step(1, 7, 0, 1, 0);
      step(1, 9, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      check_held("flush_part", mk(7, 9, 0, 0, 2));
      check("flush_sum", WD'(lane_sum()), WD'(16));
      step(0, 0, 0, 1, 0);

      // Flush coincident with an accept, then flush on an empty vector
      step(1, 1, 0, 1, 0);
      step(1, 2, 0, 1, 0);
      step(1, 3, 1, 1, 0);
      check_held("flush_coinc", mk(1, 2, 3, 0, 3));
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      check("flush_empty", WD'(bus.out_valid), WD'(0));

      // Flush on the N-th sample behaves like a normal fill
      step(1, 11, 0, 1, 0);
      step(1, 12, 0, 1, 0);
      step(1, 13, 0, 1, 0);
      step(1, 14, 1, 1, 0);
      check_held("flush_full", mk(11, 12, 13, 14, 4));
      step(0, 0, 0, 1, 0);

      // Reset mid-fill and while holding
      step(1, 8'hFF, 0, 1, 0);
      step(1, 8'hFF, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      check_held("rst_fill", mk(1, 1, 1, 1, 4));
      step(0, 0, 0, 1, 1);
      check("rst_full", WD'(bus.out_valid), WD'(0));

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 3) != 0), W'($urandom), logic'($urandom_range(0, 5) == 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 59) == 0));
      end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      check("handshakes_seen", WD'(handshakes > 20), WD'(1));

      // Non-power-of-two lane count
      bus3.out_ready = 1'b0;
      bus3.in_valid = 1'b1;
      bus3.in_data = 4'd15;
      for (int i = 0; i < N3; i++) begin
         check("n3_in_ready", WD'(bus3.in_ready), WD'(1));
         @(posedge clk);
         #1;
      end
      bus3.in_valid = 1'b0;
      check("n3_valid", WD'(bus3.out_valid), WD'(1));
      check("n3_len", WD'(bus3.out_len), WD'(3));
      s3 = '0;
      for (int i = 0; i < N3; i++) begin
         check("n3_lane", WD'(bus3.out_vec[i]), WD'(15));
         s3 = s3 + bus3.out_vec[i];
      end
      check("n3_sum", WD'(s3), WD'(13));
      bus3.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("n3_done", WD'(bus3.out_valid), WD'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sample_collector.md
# sample_collector

Serial-to-parallel buffer that sits directly upstream of the combinational adder tree. It accepts one WIDTH-bit sample per cycle on a valid/ready stream and packs N samples into a registered lane vector. It presents the vector to the tree with its own valid/ready handshake. A flush input closes a partial vector early and zero-pads the unused lanes, so the downstream sum stays correct.

## Interface
- WIDTH, 8, bit width of each sample and lane
- N, 4, lanes per vector; any value ≥ 2, not restricted to powers of two
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  sample
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  collector accepts a sample this cycle
- flush  input  1  close the current partial vector
- out_vec  output  WIDTH × [N-1:0] (unpacked)  lane vector; connects directly to the adder tree `in`
- out_len  output  $clog2(N+1)  number of lanes that hold real samples (1..N)
- out_valid  output  1  out_vec/out_len valid
- out_ready  input  1  downstream takes the vector

## Operation
- States:
  - FILL: collecting samples.
  - FULL: holding a vector until the downstream handshake.
- Accept: a sample is accepted when in_valid && in_ready.
  - The k-th accepted sample after a vector starts goes to lane k; the first sample goes to lane 0.
- FILL:
  - in_ready = 1, except while rst is high, when in_ready = 0.
  - On accept with count == N-1: the sample is written, then go to FULL with out_len = N and count = 0.
  - On flush with count > 0 and no accept: go to FULL with out_len = count. Lanes count..N-1 read 0.
  - On flush and accept in the same cycle: the sample is written first, then the vector closes with out_len = count+1. If count+1 == N, this is identical to a normal fill.
  - On flush with count == 0 and no accept: ignored, no empty vector is emitted.
- FULL:
  - in_ready = 0 and out_valid = 1.
  - flush is ignored.
  - out_vec and out_len are stable until the handshake (out_valid && out_ready).
  - On the handshake: go to FILL, clear all lanes to 0, clear count.
- Lane zeroing: every vector starts with all lanes 0. Unwritten lanes are therefore always 0, never stale data.
- Widths:
  - count is $clog2(N+1) bits.
  - There is no arithmetic on the data; samples are stored bit-exact.

## Timing
- Reset (synchronous): on the next clock edge with rst high:
  - state = FILL, count = 0, all lanes = 0, out_len = 0, out_valid = 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst is low.
- Latency:
  - out_valid rises in the cycle after the edge that accepts the N-th sample, or after the edge that registers the flush.
  - out_vec and out_valid are registered outputs.
- Throughput: at most N samples per N+1 cycles. There is one bubble cycle in which in_ready = 0, while FULL waits for out_ready.
- Backpressure: FULL may last any number of cycles while out_ready = 0. No sample is lost or duplicated.
- Reset mid-fill or while FULL: the partial or held vector is discarded. No output handshake occurs.
- out_ready while FILL: ignored.

## Structure
- Shared package (sample_pkg):
  - State typedef: enum logic {FILL, FULL}.
  - Function len_bits(n) returning $clog2(n+1).
- WIDTH and N stay module parameters, not package constants.
- No sub-module: a single always_ff for state, count and lanes, plus combinational in_ready and out_valid.
- In the integration top, out_vec feeds adder_tree with identical WIDTH and N. This instance is not part of this block.

## Test plan
- Basic fill:
  - Stimulus: N=4, samples 1,2,3,4 on consecutive cycles, out_ready=1.
  - Required: out_vec = {1,2,3,4} in lanes 0..3, out_len = 4, out_valid high for exactly 1 cycle, in_ready low in that cycle.
- Backpressure:
  - Stimulus: fill with 10,20,30,40, hold out_ready=0 for 5 cycles.
  - Required: vector stable, in_ready = 0 throughout, and in_valid pulses during the hold are not accepted. Release out_ready and the next samples 5,6,7,8 produce {5,6,7,8}.
- Flush partial:
  - Stimulus: samples 7,9 then flush.
  - Required: out_vec = {7,9,0,0}, out_len = 2. Downstream sum = 16.
- Flush coincident:
  - Stimulus: samples 1,2, then sample 3 with flush in the same cycle.
  - Required: out_vec = {1,2,3,0}, out_len = 3.
  - Stimulus: flush with count 0.
  - Required: no output.
- Reset mid-fill:
  - Stimulus: samples 0xFF,0xFF, then rst for 1 cycle, then 1,1,1,1.
  - Required: out_vec = {1,1,1,1}. No 0xFF appears in any lane.
- Non-power-of-two:
  - Stimulus: N=3, WIDTH=4, samples 15,15,15.
  - Required: out_vec = {15,15,15}, out_len = 3. Wrap of the downstream sum = 13.
